triple_lane_deinterleaver: RTL and testbench
============================================

Name: triple_lane_deinterleaver

Overview:
- Upstream stage of three_parallel_pipeline.
- Accepts one signed 16-bit sample per cycle over a valid/ready stream and groups every three consecutive samples into one block.
- Presents each block as din0/din1/din2-ordered lanes for the 3-parallel filter.
- Supports flushing a partial block with zero padding at end of stream; counts emitted blocks.

Parameters:
- DATA_W, 16, sample width in bits (matches filter input width).
- CNT_W, 32, width of emitted-block counter.

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  serial sample valid
- in_ready  out  1  block can accept sample this cycle
- in_data  in  DATA_W  signed serial sample
- flush  in  1  one-cycle request: emit any partial block, zero-padded
- out_valid  out  1  block registers hold an unconsumed block
- out_ready  in  1  downstream accepts block (tie 1 when feeding three_parallel_pipeline directly)
- out_d0  out  DATA_W  oldest sample of block (to din0)
- out_d1  out  DATA_W  middle sample (to din1)
- out_d2  out  DATA_W  newest sample (to din2)
- out_pad  out  2  number of zero-padded trailing lanes in current block (0..2)
- block_count  out  CNT_W  blocks emitted (handshakes completed) since reset

Behaviour:
- Reset (rst=1 at posedge): phase=0, lane0/lane1 staging=0, out_valid=0, out_d0..2=0, out_pad=0, block_count=0, flush_pend=0. Reset mid-block discards staged samples and any held block.
- State: phase counter 0→1→2→0. Lane0/lane1 staging registers. Output block register.
- out_free = !out_valid || out_ready (combinational).
- in_ready:
  - =1 when phase!=2.
  - =out_free when phase==2.
  - Combinational from out_ready is permitted.
  - Not gated by flush_pend.
- Accept (in_valid && in_ready):
  - phase 0: lane0 ← in_data, phase ← 1.
  - phase 1: lane1 ← in_data, phase ← 2.
  - phase 2: out_d0 ← lane0, out_d1 ← lane1, out_d2 ← in_data, out_pad ← 0, out_valid ← 1, phase ← 0.
- Latency: block visible the cycle after the third sample is accepted. Sustained throughput is 1 sample/cycle when out_ready=1.
- Output handshake:
  - out_valid && out_ready completes a block; block_count increments (wraps modulo 2^CNT_W).
  - out_valid deasserts next cycle unless a new block loads in the same cycle (back-to-back allowed).
  - out_d*/out_pad stable while out_valid && !out_ready.
- Flush:
  - flush=1 sets flush_pend.
  - flush_pend with phase_next!=0 (phase after any same-cycle accept) and out_free: load partial block.
    - phase 1: out_d0=lane0, out_d1=0, out_d2=0, out_pad=2.
    - phase 2: out_d0=lane0, out_d1=lane1, out_d2=0, out_pad=1.
  - On partial load: out_valid ← 1, phase ← 0, flush_pend ← 0.
  - flush_pend clears without output if phase_next==0.
  - Flush with a same-cycle accept: sample is accepted first, then the flush evaluates the resulting phase.
  - Flush while output is stalled: stays pending; in_ready still follows phase. Samples arriving before the flush is serviced join the partial block. If they complete a full block, that block is emitted normally and the flush clears.
- Arithmetic: no sign manipulation. Samples are copied bit-exact; padding is all-zero.

Decomposition:
- Shared package (deinterleave_pkg): DATA_W default, LANES=3 constant, phase typedef (2-bit), block struct {d0,d1,d2,pad}.
- Single module; no sub-module needed. Phase/flush control stays inline with the datapath.

Test Plan:
- Continuous stream 1,2,3,4,5,6, out_ready=1 → blocks (1,2,3) then (4,5,6) on consecutive block cycles, pad=0, block_count=2; in_ready never drops.
- Stream -1,-2,-3 with out_ready=0 for 4 cycles after out_valid → out_d*=(-1,-2,-3) held stable. Next sample 7,8 accepted (phase→2). in_ready=0 at phase 2 until out_ready=1. block_count increments only on release.
- Samples 10,20 then flush pulse → block (10,20,0), out_pad=1. Samples 30 then flush → (30,0,0), out_pad=2. Flush at phase 0 → no block.
- Third sample 9 and flush in same cycle → full block, pad=0, no extra partial block.
- Flush pulse while output stalled with phase=1 (lane0=5) → after out_ready=1, partial block (5,0,0), pad=2 emitted next.
- rst asserted with phase=2 and out_valid=1 → next cycle out_valid=0, all outputs 0, block_count=0. Next three samples form a fresh block.

Source files
------------

// File: rtl/deinterleave_pkg.sv
// Shared types for the serial-to-3-lane deinterleaver feeding the 3-parallel filter.
// Holds the default sample width, lane count, phase encoding and block layout.
package deinterleave_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int LANES      = 3;

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2
  } phase_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] d0;
    logic [DEF_DATA_W-1:0] d1;
    logic [DEF_DATA_W-1:0] d2;
    logic [1:0]            pad;
  } block_t;

endpackage

// File: rtl/triple_lane_deinterleaver.sv
// Groups 3 serial samples into one d0/d1/d2 block; block valid 1 cycle after 3rd accept.
// Third sample is held off (in_ready=0) while a block is stalled; flush emits a zero-padded partial.
module triple_lane_deinterleaver
  import deinterleave_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_d0,
  output logic signed [DATA_W-1:0] out_d1,
  output logic signed [DATA_W-1:0] out_d2,
  output logic [1:0]               out_pad,
  output logic [CNT_W-1:0]         block_count
);

  phase_t             r_phase;
  logic [DATA_W-1:0]  r_lane0, r_lane1;
  logic [DATA_W-1:0]  r_d0, r_d1, r_d2;
  logic [1:0]         r_pad;
  logic               r_out_valid;
  logic               r_flush_pend;
  logic [CNT_W-1:0]   r_count;

  logic               w_out_free, w_accept, w_fire;
  logic               w_full_load, w_part_load, w_flush_req;
  phase_t             w_phase_acc;
  logic [DATA_W-1:0]  w_lane0_nx, w_lane1_nx;

  assign w_out_free  = !r_out_valid || out_ready;
  assign in_ready    = (r_phase != PH2) || w_out_free;
  assign w_accept    = in_valid && in_ready;
  assign w_fire      = r_out_valid && out_ready;
  assign w_full_load = w_accept && (r_phase == PH2);
  assign w_flush_req = flush || r_flush_pend;
  // Flush looks at the phase after this cycle's accept, so a same-cycle sample joins the partial.
  assign w_part_load = w_flush_req && (w_phase_acc != PH0) && w_out_free;

  always_comb begin
    w_phase_acc = r_phase;
    w_lane0_nx  = r_lane0;
    w_lane1_nx  = r_lane1;
    if (w_accept) begin
      case (r_phase)
        PH0: begin
          w_lane0_nx  = in_data;
          w_phase_acc = PH1;
        end
        PH1: begin
          w_lane1_nx  = in_data;
          w_phase_acc = PH2;
        end
        default: w_phase_acc = PH0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase      <= PH0;
      r_lane0      <= '0;
      r_lane1      <= '0;
      r_d0         <= '0;
      r_d1         <= '0;
      r_d2         <= '0;
      r_pad        <= 2'd0;
      r_out_valid  <= 1'b0;
      r_flush_pend <= 1'b0;
      r_count      <= '0;
    end else begin
      r_lane0      <= w_lane0_nx;
      r_lane1      <= w_lane1_nx;
      r_flush_pend <= w_flush_req && !w_part_load && (w_phase_acc != PH0);
      if (w_fire) r_count <= r_count + CNT_W'(1);
      if (w_full_load) begin
        r_d0        <= r_lane0;
        r_d1        <= r_lane1;
        r_d2        <= in_data;
        r_pad       <= 2'd0;
        r_out_valid <= 1'b1;
        r_phase     <= PH0;
      end else if (w_part_load) begin
        r_d0        <= w_lane0_nx;
        r_d1        <= (w_phase_acc == PH2) ? w_lane1_nx : '0;
        r_d2        <= '0;
        r_pad       <= (w_phase_acc == PH2) ? 2'd1 : 2'd2;
        r_out_valid <= 1'b1;
        r_phase     <= PH0;
      end else begin
        r_phase <= w_phase_acc;
        if (w_fire) r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_d0      = r_d0;
  assign out_d1      = r_d1;
  assign out_d2      = r_d2;
  assign out_pad     = r_pad;
  assign block_count = r_count;

endmodule

// File: tb/tb_triple_lane_deinterleaver.sv
// Bench for triple_lane_deinterleaver: directed scenarios plus a random run against a
// sample-queue reference model (staged samples, pending flush, held block, block count).
module tb_triple_lane_deinterleaver;
  import deinterleave_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] in_data = '0;
  logic               flush = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [15:0] out_d0, out_d1, out_d2;
  logic [1:0]         out_pad;
  logic [31:0]        block_count;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_stage[$];
  logic        m_pend, m_held;
  block_t      m_blk;
  logic [31:0] m_count;
  logic        obs_ready, exp_ready;

  triple_lane_deinterleaver #(.DATA_W(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_d0(out_d0),
    .out_d1(out_d1), .out_d2(out_d2), .out_pad(out_pad), .block_count(block_count)
  );

  always #5 clk = ~clk;

  // Drives one cycle of inputs and advances the reference model across the clock edge.
  task automatic cycle(input logic v, input logic [15:0] d, input logic f, input logic r,
                       input logic rs = 1'b0);
    logic free, fr;
    in_valid = v; in_data = d; flush = f; out_ready = r; rst = rs;
    #2;
    obs_ready = in_ready;
    exp_ready = (m_stage.size() < 2) || !m_held || r;
    @(posedge clk);
    if (rs) begin
      m_stage.delete(); m_pend = 1'b0; m_held = 1'b0; m_blk = '0; m_count = '0;
    end else begin
      free = !m_held || r;
      if (m_held && r) begin m_count = m_count + 1; m_held = 1'b0; end
      if (v && exp_ready) begin
        m_stage.push_back(d);
        if (m_stage.size() == 3) begin
          m_blk = '{d0: m_stage[0], d1: m_stage[1], d2: m_stage[2], pad: 2'd0};
          m_held = 1'b1;
          m_stage.delete();
        end
      end
      fr = f || m_pend;
      if (fr && m_stage.size() > 0 && free) begin
        m_blk.d0  = m_stage[0];
        m_blk.d1  = (m_stage.size() > 1) ? m_stage[1] : 16'd0;
        m_blk.d2  = 16'd0;
        m_blk.pad = 2'(3 - m_stage.size());
        m_held = 1'b1;
        m_stage.delete();
        m_pend = 1'b0;
      end else begin
        m_pend = fr && (m_stage.size() > 0);
      end
    end
    #1;
  endtask

  task automatic test_reset;
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b0 || out_pad !== 2'd0 || block_count !== 32'd0 ||
        {out_d0, out_d1, out_d2} !== 48'd0) begin
      errors++;
      $display("FAIL reset_state got v=%b d=%h/%h/%h pad=%0d cnt=%0d want all zero",
               out_valid, out_d0, out_d1, out_d2, out_pad, block_count);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
  endtask

  task automatic test_stream;
    cycle(0, 0, 0, 0, 1);
    for (int i = 1; i <= 6; i++) begin
      cycle(1, 16'(i), 0, 1);
      checks++;
      if (obs_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %b want 1", i, obs_ready); end
      if (i == 3 || i == 6) begin
        checks++;
        if (out_valid !== 1'b1 || out_d0 !== 16'(i-2) || out_d1 !== 16'(i-1) || out_d2 !== 16'(i) || out_pad !== 2'd0) begin
          errors++;
          $display("FAIL stream_blk%0d got v=%b %0d,%0d,%0d pad=%0d want 1 %0d,%0d,%0d pad=0",
                   i/3, out_valid, out_d0, out_d1, out_d2, out_pad, i-2, i-1, i);
        end
      end
    end
    cycle(0, 0, 0, 1);
    checks++;
    if (block_count !== 32'd2 || out_valid !== 1'b0) begin
      errors++; $display("FAIL stream_count got cnt=%0d v=%b want cnt=2 v=0", block_count, out_valid);
    end
  endtask

  task automatic test_stall;
    cycle(0, 0, 0, 0, 1);
    cycle(1, 16'hFFFF, 0, 0); cycle(1, 16'hFFFE, 0, 0); cycle(1, 16'hFFFD, 0, 0);
    for (int i = 0; i < 4; i++) begin
      if (i < 2) cycle(1, 16'(7 + i), 0, 0); else cycle(0, 0, 0, 0);
      checks++;
      if (out_valid !== 1'b1 || {out_d0, out_d1, out_d2} !== 48'hFFFF_FFFE_FFFD || block_count !== 32'd0) begin
        errors++;
        $display("FAIL stall_hold[%0d] got v=%b %h,%h,%h cnt=%0d want 1 ffff,fffe,fffd cnt=0",
                 i, out_valid, out_d0, out_d1, out_d2, block_count);
      end
    end
    cycle(1, 16'd9, 0, 0);
    checks++;
    if (obs_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_ph2 got %b want 0", obs_ready); end
    cycle(1, 16'd9, 0, 1);
    checks++;
    if (obs_ready !== 1'b1 || block_count !== 32'd1 || {out_d0, out_d1, out_d2} !== {16'd7, 16'd8, 16'd9}) begin
      errors++;
      $display("FAIL stall_release got rdy=%b cnt=%0d %0d,%0d,%0d want rdy=1 cnt=1 7,8,9",
               obs_ready, block_count, out_d0, out_d1, out_d2);
    end
  endtask

  task automatic test_flush_partial;
    cycle(0, 0, 0, 0, 1);
    cycle(1, 16'd10, 0, 1); cycle(1, 16'd20, 0, 1); cycle(0, 0, 1, 1);
    checks++;
    if (out_valid !== 1'b1 || {out_d0, out_d1, out_d2} !== {16'd10, 16'd20, 16'd0} || out_pad !== 2'd1) begin
      errors++;
      $display("FAIL flush_ph2 got v=%b %0d,%0d,%0d pad=%0d want 1 10,20,0 pad=1", out_valid, out_d0, out_d1, out_d2, out_pad);
    end
    cycle(1, 16'd30, 0, 1); cycle(0, 0, 1, 1);
    checks++;
    if (out_valid !== 1'b1 || {out_d0, out_d1, out_d2} !== {16'd30, 16'd0, 16'd0} || out_pad !== 2'd2) begin
      errors++;
      $display("FAIL flush_ph1 got v=%b %0d,%0d,%0d pad=%0d want 1 30,0,0 pad=2", out_valid, out_d0, out_d1, out_d2, out_pad);
    end
    cycle(0, 0, 1, 1); cycle(0, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b0 || block_count !== 32'd2) begin
      errors++; $display("FAIL flush_ph0 got v=%b cnt=%0d want v=0 cnt=2", out_valid, block_count);
    end
  endtask

  task automatic test_flush_same_cycle;
    cycle(0, 0, 0, 0, 1);
    cycle(1, 16'd1, 0, 1); cycle(1, 16'd2, 0, 1); cycle(1, 16'd9, 1, 1);
    checks++;
    if (out_valid !== 1'b1 || {out_d0, out_d1, out_d2} !== {16'd1, 16'd2, 16'd9} || out_pad !== 2'd0) begin
      errors++;
      $display("FAIL flush_same got v=%b %0d,%0d,%0d pad=%0d want 1 1,2,9 pad=0", out_valid, out_d0, out_d1, out_d2, out_pad);
    end
    cycle(1, 16'd4, 0, 1); cycle(0, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b0 || block_count !== 32'd1) begin
      errors++; $display("FAIL flush_same_extra got v=%b cnt=%0d want v=0 cnt=1", out_valid, block_count);
    end
  endtask

  task automatic test_flush_stalled;
    cycle(0, 0, 0, 0, 1);
    cycle(1, 16'd1, 0, 0); cycle(1, 16'd2, 0, 0); cycle(1, 16'd3, 0, 0);
    cycle(1, 16'd5, 0, 0); cycle(0, 0, 1, 0); cycle(0, 0, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || {out_d0, out_d1, out_d2} !== {16'd1, 16'd2, 16'd3} || obs_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_stall_hold got v=%b %0d,%0d,%0d rdy=%b want 1 1,2,3 rdy=1", out_valid, out_d0, out_d1, out_d2, obs_ready);
    end
    cycle(0, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b1 || {out_d0, out_d1, out_d2} !== {16'd5, 16'd0, 16'd0} || out_pad !== 2'd2 || block_count !== 32'd1) begin
      errors++;
      $display("FAIL flush_stall_part got v=%b %0d,%0d,%0d pad=%0d cnt=%0d want 1 5,0,0 pad=2 cnt=1",
               out_valid, out_d0, out_d1, out_d2, out_pad, block_count);
    end
  endtask

  task automatic test_reset_mid;
    cycle(0, 0, 0, 0, 1);
    cycle(1, 16'd1, 0, 0); cycle(1, 16'd2, 0, 0); cycle(1, 16'd3, 0, 0);
    cycle(1, 16'd4, 0, 0); cycle(1, 16'd5, 0, 0);
    cycle(0, 0, 0, 0, 1);
    checks++;
    if (out_valid !== 1'b0 || {out_d0, out_d1, out_d2} !== 48'd0 || out_pad !== 2'd0 || block_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid got v=%b %h,%h,%h pad=%0d cnt=%0d want all zero", out_valid, out_d0, out_d1, out_d2, out_pad, block_count);
    end
    cycle(1, 16'd11, 0, 1); cycle(1, 16'd12, 0, 1); cycle(1, 16'd13, 0, 1);
    checks++;
    if (out_valid !== 1'b1 || {out_d0, out_d1, out_d2} !== {16'd11, 16'd12, 16'd13}) begin
      errors++;
      $display("FAIL reset_fresh got v=%b %0d,%0d,%0d want 1 11,12,13", out_valid, out_d0, out_d1, out_d2);
    end
  endtask

  task automatic test_random;
    logic bad;
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 3) != 0), 16'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0));
      bad = (obs_ready !== exp_ready) || (out_valid !== m_held) || (block_count !== m_count) ||
            (m_held && ({out_d0, out_d1, out_d2, out_pad} !== m_blk));
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL random[%0d] got rdy=%b v=%b %h,%h,%h pad=%0d cnt=%0d want rdy=%b v=%b %h,%h,%h pad=%0d cnt=%0d",
                 i, obs_ready, out_valid, out_d0, out_d1, out_d2, out_pad, block_count,
                 exp_ready, m_held, m_blk.d0, m_blk.d1, m_blk.d2, m_blk.pad, m_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush_partial();
    test_flush_same_cycle();
    test_flush_stalled();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
